// File: rtl/adapter_4_to_1_synth.sv
`timescale 1ns/1ps
// Four-lane to one-lane width adapter: combinational packed bus plus a
// registered valid/ready serializer that emits each captured word lane 0..3.
module adapter_4_to_1_synth #(
    parameter int DATA_WIDTH = 16,
    parameter int N_INPUTS   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_WIDTH-1:0]          r0,
    input  logic [DATA_WIDTH-1:0]          r1,
    input  logic [DATA_WIDTH-1:0]          r2,
    input  logic [DATA_WIDTH-1:0]          r3,
    output logic [N_INPUTS*DATA_WIDTH-1:0] r,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [1:0]                     out_lane,
    output logic                           out_valid,
    input  logic                           out_ready
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                      state, stateNext;
    logic [3:0][DATA_WIDTH-1:0]  hold, holdNext;
    logic [DATA_WIDTH-1:0]       dataNext;
    logic [1:0]                  laneNext;
    logic                        validNext;
    logic                        lastAccept;

    assign r = {r3, r2, r1, r0};

    // A word may be taken in the same edge that the last lane of the previous one leaves.
    assign lastAccept = out_valid && out_ready && (out_lane == 2'd3);
    assign in_ready   = (state == IDLE) || lastAccept;

    always_comb begin
        stateNext = state;
        holdNext  = hold;
        dataNext  = out_data;
        laneNext  = out_lane;
        validNext = out_valid;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    holdNext  = {r3, r2, r1, r0};
                    dataNext  = r0;
                    laneNext  = 2'd0;
                    validNext = 1'b1;
                    stateNext = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (out_lane != 2'd3) begin
                        laneNext = out_lane + 2'd1;
                        dataNext = hold[out_lane + 2'd1];
                    end else if (in_valid) begin
                        holdNext  = {r3, r2, r1, r0};
                        dataNext  = r0;
                        laneNext  = 2'd0;
                        validNext = 1'b1;
                    end else begin
                        validNext = 1'b0;
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hold      <= '0;
            out_data  <= '0;
            out_lane  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= stateNext;
            hold      <= holdNext;
            out_data  <= dataNext;
            out_lane  <= laneNext;
            out_valid <= validNext;
        end
    end

endmodule

// File: tb/tb_adapter_4_to_1_synth.sv
`timescale 1ns/1ps
// Self-checking bench for adapter_4_to_1_synth: packing vectors, directed
// serializer sequences and a queue-based random reference model.
module tb_adapter_4_to_1_synth;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] r0, r1, r2, r3;
    logic [4*DW-1:0] r;
    logic          in_valid, in_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_lane;
    logic          out_valid, out_ready;

    int unsigned tests = 0;
    int unsigned fails = 0;

    adapter_4_to_1_synth #(.DATA_WIDTH(DW), .N_INPUTS(4)) dut (
        .clk(clk), .reset(reset),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r(r),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_lane(out_lane),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]   a0, a1, a2, a3;
        logic [4*DW-1:0] exp;
    } packVec_t;

    packVec_t vecs[3];
    logic [17:0] beatQ[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setWord(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                           input logic [DW-1:0] a2, input logic [DW-1:0] a3);
        r0 = a0; r1 = a1; r2 = a2; r3 = a3;
    endtask

    task automatic checkBeat(input string name, input logic [1:0] lane, input logic [DW-1:0] data);
        check({name, ".valid"}, 64'(out_valid), 64'd1);
        check({name, ".lane"},  64'(out_lane),  64'(lane));
        check({name, ".data"},  64'(out_data),  64'(data));
    endtask

    initial begin
        logic expReady, pushNow, popNow;
        logic [DW-1:0] w0, w1, w2, w3;
        logic [17:0] front;

        vecs[0] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 64'hCDEF_89AB_4567_0123};
        vecs[1] = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123, 64'h0123_4567_89AB_CDEF};
        vecs[2] = '{16'hAAAA, 16'h0AAA, 16'h00BB, 16'h0123, 64'h0123_00BB_0AAA_AAAA};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        setWord('0, '0, '0, '0);
        #3;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.out_data",  64'(out_data),  64'd0);
        check("rst.out_lane",  64'(out_lane),  64'd0);
        check("rst.in_ready",  64'(in_ready),  64'd1);

        // Packing while reset is held: no clock edge between drive and check.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            setWord(vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].a3);
            #1 check($sformatf("pack_rst[%0d]", i), r, vecs[i].exp);
        end
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            setWord(vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].a3);
            #1 check($sformatf("pack[%0d]", i), r, vecs[i].exp);
        end

        // Single word
        @(negedge clk);
        setWord(16'h0123, 16'h4567, 16'h89AB, 16'hCDEF);
        in_valid = 1'b1; out_ready = 1'b1;
        tick(); in_valid = 1'b0;
        checkBeat("one.b0", 2'd0, 16'h0123);
        tick(); checkBeat("one.b1", 2'd1, 16'h4567);
        tick(); checkBeat("one.b2", 2'd2, 16'h89AB);
        tick(); checkBeat("one.b3", 2'd3, 16'hCDEF);
        check("one.ready_last", 64'(in_ready), 64'd1);
        tick();
        check("one.idle_valid", 64'(out_valid), 64'd0);
        check("one.idle_ready", 64'(in_ready), 64'd1);

        // Backpressure on lane 1 plus input isolation
        in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        checkBeat("bp.b0", 2'd0, 16'h0123);
        check("bp.busy_ready", 64'(in_ready), 64'd0);
        tick(); checkBeat("bp.b1", 2'd1, 16'h4567);
        out_ready = 1'b0;
        setWord(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        #1 check("iso.r", r, 64'h4444_3333_2222_1111);
        for (int i = 0; i < 3; i++) begin
            tick(); checkBeat($sformatf("bp.hold%0d", i), 2'd1, 16'h4567);
        end
        out_ready = 1'b1;
        tick(); checkBeat("bp.b2", 2'd2, 16'h89AB);
        tick(); checkBeat("bp.b3", 2'd3, 16'hCDEF);
        tick(); check("bp.idle", 64'(out_valid), 64'd0);

        // Back-to-back words
        setWord(16'hA000, 16'hA001, 16'hA002, 16'hA003);
        in_valid = 1'b1;
        tick();
        setWord(16'hB000, 16'hB001, 16'hB002, 16'hB003);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) in_valid = 1'b0;
            checkBeat($sformatf("b2b.%0d", i), 2'(i % 4),
                      16'((i < 4 ? 16'hA000 : 16'hB000) + (i % 4)));
            tick();
        end
        check("b2b.idle", 64'(out_valid), 64'd0);

        // Reset mid-word
        setWord(16'hC000, 16'hC001, 16'hC002, 16'hC003);
        in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        tick(); tick();
        checkBeat("rmw.b2", 2'd2, 16'hC002);
        #2 reset = 1'b1;
        #1;
        check("rmw.valid", 64'(out_valid), 64'd0);
        check("rmw.data",  64'(out_data),  64'd0);
        check("rmw.lane",  64'(out_lane),  64'd0);
        check("rmw.ready", 64'(in_ready),  64'd1);
        check("rmw.r",     r, 64'hC003_C002_C001_C000);
        @(negedge clk) reset = 1'b0;
        #1 check("rmw.post_ready", 64'(in_ready), 64'd1);
        setWord(16'hD000, 16'hD001, 16'hD002, 16'hD003);
        in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        checkBeat("rmw.new_b0", 2'd0, 16'hD000);
        for (int i = 0; i < 5; i++) tick();
        check("rmw.drained", 64'(out_valid), 64'd0);

        // Random traffic against a queue of outstanding beats
        beatQ.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            w0 = 16'($urandom); w1 = 16'($urandom);
            w2 = 16'($urandom); w3 = 16'($urandom);
            setWord(w0, w1, w2, w3);
            #1;
            expReady = (beatQ.size() == 0) || (beatQ.size() == 1 && out_ready);
            check("rnd.in_ready",  64'(in_ready),  64'(expReady));
            check("rnd.out_valid", 64'(out_valid), 64'(beatQ.size() != 0));
            if (beatQ.size() != 0) begin
                front = beatQ[0];
                check("rnd.out_lane", 64'(out_lane), 64'(front[17:16]));
                check("rnd.out_data", 64'(out_data), 64'(front[15:0]));
            end
            popNow  = (beatQ.size() != 0) && out_ready;
            pushNow = in_valid && expReady;
            @(posedge clk);
            if (popNow) void'(beatQ.pop_front());
            if (pushNow) begin
                beatQ.push_back({2'd0, w0});
                beatQ.push_back({2'd1, w1});
                beatQ.push_back({2'd2, w2});
                beatQ.push_back({2'd3, w3});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
